// File: rtl/lab2_pkg.sv
// Shared definitions for the lab2 timer family: FSM state encoding and default width.
package lab2_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/lab2_4_countdown_timer.sv
// Loadable countdown timer with start/stop, optional auto-reload and a one-cycle done pulse.
module lab2_4_countdown_timer
  import lab2_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      reload_d = load_val;
      count_d  = load_val;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // stop outranks start even though stop alone does nothing in IDLE
          if (start && !stop) begin
            if (count_q != '0) begin
              state_d = ST_RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            // Unreachable via normal operation; park safely without wrapping.
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_lab2_4_countdown_timer.sv
// Scoreboard bench for the countdown timer: reference model pushes expectations, monitor checks.
module tb_lab2_4_countdown_timer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  typedef struct {
    int count;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;

  // Reference model state: remaining count, running flag, remembered period.
  int m_cnt;
  bit m_run;
  int m_reload;

  lab2_4_countdown_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin : model
    int   c;
    bit   r;
    bit   d;
    int   rl;
    exp_t e;
    if (!reset_n) begin
      m_cnt    <= 0;
      m_run    <= 1'b0;
      m_reload <= 0;
    end else begin
      c  = m_cnt;
      r  = m_run;
      rl = m_reload;
      d  = 1'b0;
      if (load) begin
        c  = int'(load_val);
        rl = int'(load_val);
        r  = 1'b0;
      end else if (r) begin
        if (stop) begin
          r = 1'b0;
        end else if (c > 1) begin
          c = c - 1;
        end else if (c == 1) begin
          d = 1'b1;
          if (auto_reload) c = rl;
          else begin
            c = 0;
            r = 1'b0;
          end
        end else begin
          r = 1'b0;
        end
      end else if (start && !stop) begin
        if (c == 0) d = 1'b1;
        else r = 1'b1;
      end
      m_cnt    <= c;
      m_run    <= r;
      m_reload <= rl;
      e.count = c;
      e.busy  = r;
      e.done  = d;
      exp_q.push_back(e);
    end
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (count !== W'(e.count) || busy !== e.busy || done !== e.done) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                 $time, count, busy, done, e.count, e.busy, e.done);
      end
    end
    if (done === 1'b1) done_seen++;
  end

  task automatic step(input logic l, input logic [W-1:0] lv, input logic st, input logic sp,
                      input logic ar);
    @(negedge clk);
    load        = l;
    load_val    = lv;
    start       = st;
    stop        = sp;
    auto_reload = ar;
  endtask

  task automatic idle(input int n, input logic ar);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, ar);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%b done=%b, want count=0 busy=0 done=0",
               name, count, busy, done);
    end
  endtask

  // Assert reset between edges, check outputs without any clock edge, then release.
  task automatic async_reset(input string name);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs(name);
    load = 1'b0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int base;
    #1 check_reset_outputs("power_on_reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Async reset with nonzero count while running
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    async_reset("async_reset_running");

    // One-shot of 3
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b0);

    // Periodic mode of 4: three pulses within 12 cycles after start
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    base = done_seen;
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(12, 1'b1);
    @(negedge clk);
    checks++;
    if (done_seen - base != 3) begin
      errors++;
      $display("FAIL auto_reload_pulses: got %0d done pulses, want 3", done_seen - base);
    end
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

    // Stop/resume from 9
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);

    // Zero load then start
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Load + start together while running
    step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Reset at count 2 aborts with no done
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    async_reset("async_reset_at_two");
    idle(4, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), W'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 149) == 0) async_reset("async_reset_random");
    end
    idle(3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
